// File: rtl/qrange_gen_if.sv
// Valid/ready stream bundle used for both the descriptor input and the queue output of qrange_gen.
// The master drives valid/data, the slave drives ready.
interface qrange_gen_if #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qrange_gen.sv
// qrange_gen: expands one {incr, stop, start} descriptor into a level-1 queue start, start+incr, ...
// with eot on the final element. Define QRANGE_INCLUSIVE_EN to make stop inclusive (default: exclusive).
module qrange_gen #(
  parameter int W_CNT = 16
) (
  input  logic         clk,
  input  logic         rst,
  qrange_gen_if.slave  din,
  qrange_gen_if.master dout
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W_CNT-1:0] cur;
  logic [W_CNT-1:0] cur_nxt;
  logic [W_CNT-1:0] start;
  logic [W_CNT-1:0] stop;
  logic [W_CNT-1:0] incr;
  logic [W_CNT-1:0] val;
  logic [W_CNT:0]   nxt;
  logic             last;
  logic             empty;
  logic             xfer;

  // A zero increment is promoted to 1 so a queue can never stall on one value.
  function automatic logic [W_CNT-1:0] eff_step(input logic [W_CNT-1:0] inc);
    return (inc == '0) ? W_CNT'(1) : inc;
  endfunction

  // True when v lies outside the range bounded by lim; one extra bit keeps the sum from wrapping.
  function automatic logic past_end(input logic [W_CNT:0] v, input logic [W_CNT-1:0] lim);
`ifdef QRANGE_INCLUSIVE_EN
    return v > {1'b0, lim};
`else
    return v >= {1'b0, lim};
`endif
  endfunction

  assign start = din.data[0       +: W_CNT];
  assign stop  = din.data[W_CNT   +: W_CNT];
  assign incr  = din.data[2*W_CNT +: W_CNT];

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    val        = (state == RUN) ? cur : start;
    nxt        = {1'b0, val} + {1'b0, eff_step(incr)};
    last       = past_end(nxt, stop);
    empty      = (state == IDLE) && past_end({1'b0, start}, stop);
    dout.valid = rst && din.valid && !empty;
    dout.data  = {last, val};
    din.ready  = rst && din.valid && (empty || (dout.ready && last));
    xfer       = dout.valid && dout.ready;
    if (xfer) begin
      if (last) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = RUN;
        cur_nxt   = nxt[W_CNT-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
    end
  end
endmodule

// File: doc/qrange_gen.md
# qrange_gen

Queue generator that sits directly upstream of `qlen_cnt`. It accepts one range descriptor {start, stop, incr} per input transaction and emits a level-1 queue of values start, start+incr, ... bounded by stop, with eot set on the final element. Output format is {eot[0], data[W_CNT-1:0]}, so it plugs straight into `qlen_cnt` with TDIN=W_CNT, DIN_LVL=1. The block is zero-latency and combinational on the data path; its only state is the running value and a busy flag.

## Interface
- W_CNT, 16, width of start, stop, incr and of each emitted value
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 resets)
- din  dti.consumer  3*W_CNT  packed {incr, stop, start}; start in the LSBs
- dout  dti.producer  W_CNT+1  packed {eot, data}; eot is the MSB

## Operation
- State: `busy` (1 bit) and `cur` (W_CNT bits). IDLE = !busy, RUN = busy.
- Emitted value: `val = busy ? cur : start`.
- Effective step: `step = (incr == 0) ? 1 : incr`. Zero incr never stalls the queue.
- Next value: `nxt = val + step`, computed in W_CNT+1 bits. All comparisons against stop use W_CNT+1 bits, so the sum never wraps.
- `last` (default build): `nxt >= stop`.
- `empty` (default build): `start >= stop`, evaluated in IDLE only.
- dout.data is {last, val}.
- dout.valid = rst && din.valid && !empty.
- din.ready = rst && din.valid && (empty || (dout.ready && last)).
  - The descriptor is consumed in the same cycle as the eot handshake.
  - An empty descriptor is consumed with no dout transfer.
- Transitions:
  - IDLE -> RUN on a dout handshake with !last; cur <= nxt.
  - RUN -> RUN on a dout handshake with !last; cur <= nxt.
  - RUN -> IDLE on a dout handshake with last.
  - IDLE stays IDLE on a handshake with last, i.e. a single-element queue.
  - No handshake: state holds.
- Upstream must hold din stable while din.valid && !din.ready. A change mid-queue is a protocol violation, and its output is undefined.

## Timing
- Reset (rst==0 at a clock edge): busy <= 0, cur <= 0. While rst==0, dout.valid and din.ready are 0.
- Latency from din to dout is 0 cycles. The first element is valid in the same cycle din.valid rises.
- Throughput is 1 element/cycle while dout.ready=1. A queue of K elements holds din for exactly K cycles.
- Back-to-back descriptors: the first element of the next queue can appear in the cycle after the eot handshake, with no bubble.
- An empty descriptor costs 1 cycle with dout.valid=0.
- Reset during RUN aborts the current queue. After reset is released, the descriptor still on din restarts from start.
- dout.ready low holds val and eot stable, because state is frozen.
- Boundaries:
  - stop = 2^W_CNT-1 with start near max: no wrap, because the compare is W_CNT+1 bits.
  - incr larger than stop-start gives a single-element queue.

## Configuration
- QRANGE_INCLUSIVE_EN defined: stop is inclusive.
  - last = `nxt > stop`
  - empty = `start > stop`
  - start == stop emits one element.
- QRANGE_INCLUSIVE_EN undefined: stop is exclusive, as described in Operation.
  - start == stop is empty: consumed in 1 cycle, no output.

## Test plan
- {start=0, stop=4, incr=1}, dout.ready=1 -> data 0,1,2,3 on 4 consecutive cycles. eot only on 3. din.ready only in cycle 4. Feeding this into `qlen_cnt` yields count 4.
- {start=3, stop=10, incr=3} -> 3,6,9 with eot on 9. With QRANGE_INCLUSIVE_EN and stop=9 -> 3,6,9, same eot.
- {start=5, stop=5, incr=1} -> default build: din consumed in 1 cycle, dout.valid never high. Inclusive build: single element 5 with eot=1.
- {start=0xFFFE, stop=0xFFFF, incr=0}, W_CNT=16 -> incr treated as 1. Single element 0xFFFE with eot=1 and no wrap. Inclusive build: 0xFFFE, 0xFFFF, eot on 0xFFFF.
- {start=0, stop=8, incr=2} with dout.ready toggled 1,0,0,1,1,0,1 -> values 0,2,4,6 in order, each held stable while ready=0. eot on 6. No element skipped or duplicated.
- Mid-queue reset: {start=0, stop=6, incr=1}. Assert rst=0 for 1 cycle after 0,1 are transferred -> during reset dout.valid=0 and din.ready=0. After release the sequence restarts at 0 and completes 0..5.
